// File: rtl/aes256_pkg.sv
// Shared AES-256 definitions: round count, pipeline latency, S-box and Rcon
// tables, and the byte/word/state transforms used by every pipeline stage.
package aes256_pkg;

    localparam int unsigned NR      = 32'd14;
    localparam int unsigned LATENCY = 32'd15;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants for key-schedule words 8, 16, ..., 56 (entry 0 first).
    localparam logic [55:0] RCON_TABLE = 56'h01_02_04_08_10_20_40;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = 11'd2047 - {b, 3'b000};
        return SBOX_TABLE[idx -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [2:0] k);
        logic [5:0] idx;
        logic [7:0] r;
        if (k > 3'd6) begin
            r = 8'h00;
        end else begin
            idx = 6'd55 - {k, 3'b000};
            r   = RCON_TABLE[idx -: 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        return {sub_word(s[127:96]), sub_word(s[95:64]),
                sub_word(s[63:32]), sub_word(s[31:0])};
    endfunction

    // Byte index r+4c (row r, column c) takes the byte from column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [0:15][7:0] b;
        b = s;
        return {b[0],  b[5],  b[10], b[15],
                b[4],  b[9],  b[14], b[3],
                b[8],  b[13], b[2],  b[7],
                b[12], b[1],  b[6],  b[11]};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]), mix_column(s[31:0])};
    endfunction

endpackage

// File: rtl/aes256_round.sv
// One pipelined AES-256 round. The incoming key window holds schedule words
// w[4(RND-1)] .. w[4(RND-1)+7]; its lower half is this round's key, and the
// outgoing window is advanced by four words for the next round.
module aes256_round
    import aes256_pkg::*;
#(
    parameter int unsigned RND = 32'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] state_in,
    input  logic [255:0] key_in,
    input  logic         final_round,
    output logic [127:0] state_out,
    output logic [255:0] key_out
);

    // New words start at index 4*RND+4: a multiple of 8 for odd rounds
    // (RotWord+SubWord+Rcon), otherwise index mod 8 == 4 (SubWord only).
    localparam logic       ODD_ROUND = ((RND % 32'd2) == 32'd1);
    localparam logic [2:0] RCON_IDX  = 3'((RND - 32'd1) / 32'd2);

    logic [127:0] shifted_s;
    logic [127:0] pre_key_s;
    logic [127:0] state_next_s;
    logic [31:0]  temp_s;
    logic [31:0]  nw0_s, nw1_s, nw2_s, nw3_s;
    logic [255:0] key_next_s;
    logic [127:0] state_r;
    logic [255:0] key_r;

    // Round datapath and next key-schedule window.
    always_comb begin
        shifted_s = shift_rows(sub_bytes(state_in));
        if (final_round) begin
            pre_key_s = shifted_s;
        end else begin
            pre_key_s = mix_columns(shifted_s);
        end
        state_next_s = pre_key_s ^ key_in[127:0];

        if (ODD_ROUND) begin
            temp_s = sub_word(rot_word(key_in[31:0])) ^ {rcon(RCON_IDX), 24'h000000};
        end else begin
            temp_s = sub_word(key_in[31:0]);
        end
        nw0_s      = key_in[255:224] ^ temp_s;
        nw1_s      = key_in[223:192] ^ nw0_s;
        nw2_s      = key_in[191:160] ^ nw1_s;
        nw3_s      = key_in[159:128] ^ nw2_s;
        key_next_s = {key_in[127:0], nw0_s, nw1_s, nw2_s, nw3_s};
    end

    // Stage registers for state and key window, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= 128'd0;
            key_r   <= 256'd0;
        end else begin
            state_r <= state_next_s;
            key_r   <= key_next_s;
        end
    end

    assign state_out = state_r;
    assign key_out   = key_r;

endmodule

// File: rtl/top.sv
// Fully pipelined AES-256 encryptor: one block and one key accepted every
// cycle, ciphertext available 15 rising edges after the inputs are sampled.
module top
    import aes256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] PlainText,
    input  logic [255:0] Key,
    output logic [127:0] CipherText
);

    logic [127:0] state_s [0:NR];
    logic [255:0] key_s   [0:NR];
    logic [127:0] state0_r;
    logic [255:0] key0_r;
    logic [255:0] key_unused_s;

    // Stage 0: initial AddRoundKey and capture of the full cipher key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state0_r <= 128'd0;
            key0_r   <= 256'd0;
        end else begin
            state0_r <= PlainText ^ Key[255:128];
            key0_r   <= Key;
        end
    end

    assign state_s[0] = state0_r;
    assign key_s[0]   = key0_r;

    for (genvar g = 1; g <= int'(NR); g++) begin : g_round
        aes256_round #(
            .RND(g)
        ) u_round (
            .clk        (clk),
            .rst_n      (rst_n),
            .state_in   (state_s[g-1]),
            .key_in     (key_s[g-1]),
            .final_round((g == int'(NR)) ? 1'b1 : 1'b0),
            .state_out  (state_s[g]),
            .key_out    (key_s[g])
        );
    end

    // The window leaving the last round has no consumer.
    assign key_unused_s = key_s[NR];
    assign CipherText   = state_s[NR];

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the AES-256 pipeline: known-answer vectors,
// back-to-back and key-alternating streams, async reset flush, and random
// blocks against an independent software model.
module tb_top;

    localparam logic [255:0] C3_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] ZERO_CT = 128'hdc95c078a2408989ad48a21492842087;

    logic         clk;
    logic         rst_n;
    logic [127:0] PlainText;
    logic [255:0] Key;
    logic [127:0] CipherText;

    int n_cmp;
    int n_err;

    logic [7:0]   tb_sbox [256];
    logic [127:0] vec_pt  [64];
    logic [255:0] vec_key [64];
    logic [127:0] vec_ct  [64];

    top dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PlainText (PlainText),
        .Key       (Key),
        .CipherText(CipherText)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return (a[7]) ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse and the affine map.
    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            if (i != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(i));
            end
            x = inv;
            tb_sbox[i] = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                         ^ {x[3:0], x[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [255:0] key);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   b [16];
        logic [7:0]   n [16];
        logic [127:0] st;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        st = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 16; i++) b[i] = tb_sbox[st[127 - 8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) n[q + 4*c] = b[q + 4*((c + q) % 4)];
            if (r < 14) begin
                for (int c = 0; c < 4; c++) begin
                    b[4*c]   = gmul(n[4*c], 8'h02) ^ gmul(n[4*c+1], 8'h03) ^ n[4*c+2] ^ n[4*c+3];
                    b[4*c+1] = n[4*c] ^ gmul(n[4*c+1], 8'h02) ^ gmul(n[4*c+2], 8'h03) ^ n[4*c+3];
                    b[4*c+2] = n[4*c] ^ n[4*c+1] ^ gmul(n[4*c+2], 8'h02) ^ gmul(n[4*c+3], 8'h03);
                    b[4*c+3] = gmul(n[4*c], 8'h03) ^ n[4*c+1] ^ n[4*c+2] ^ gmul(n[4*c+3], 8'h02);
                end
            end else begin
                for (int i = 0; i < 16; i++) b[i] = n[i];
            end
            for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = b[i];
            st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return st;
    endfunction

    // Feed vectors 0..n-1 on consecutive edges; each result is checked
    // exactly 14 edges after the edge that sampled its inputs.
    task automatic run_stream(input string name, input int n);
        for (int t = 0; t < n + 14; t++) begin
            if (t < n) begin
                PlainText = vec_pt[t];
                Key       = vec_key[t];
            end else begin
                PlainText = 128'd0;
                Key       = 256'd0;
            end
            @(posedge clk);
            #1;
            if (t >= 14) check_eq($sformatf("%s_%0d", name, t - 14), CipherText, vec_ct[t - 14]);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        PlainText = 128'd0;
        Key       = 256'd0;
        build_sbox();

        check_eq("model_c3", aes_model(C3_PT, C3_KEY), C3_CT);
        check_eq("model_zero", aes_model(128'd0, 256'd0), ZERO_CT);

        #2;
        check_eq("reset_ct", CipherText, 128'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ct_clocked", CipherText, 128'd0);
        #3;
        rst_n = 1'b1;

        vec_pt[0] = C3_PT;          vec_key[0] = C3_KEY; vec_ct[0] = C3_CT;
        vec_pt[1] = 128'd0;         vec_key[1] = 256'd0; vec_ct[1] = ZERO_CT;
        for (int i = 2; i < 8; i++) begin
            vec_pt[i]  = (i == 2) ? C3_PT : (C3_PT ^ {16{8'(i)}});
            vec_key[i] = C3_KEY;
            vec_ct[i]  = (i == 2) ? C3_CT : aes_model(vec_pt[i], C3_KEY);
        end
        for (int i = 8; i < 16; i++) begin
            vec_pt[i]  = (i % 2 == 0) ? C3_PT : 128'd0;
            vec_key[i] = (i % 2 == 0) ? C3_KEY : 256'd0;
            vec_ct[i]  = (i % 2 == 0) ? C3_CT : ZERO_CT;
        end
        for (int i = 16; i < 36; i++) begin
            vec_pt[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
            vec_key[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()};
            vec_ct[i]  = aes_model(vec_pt[i], vec_key[i]);
        end
        run_stream("main", 36);

        PlainText = C3_PT;
        Key       = 256'd0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_clear", CipherText, 128'd0);
        @(posedge clk);
        #1;
        check_eq("reset_hold", CipherText, 128'd0);
        #3;
        rst_n = 1'b1;

        vec_pt[0] = C3_PT;  vec_key[0] = C3_KEY; vec_ct[0] = C3_CT;
        vec_pt[1] = 128'd0; vec_key[1] = 256'd0; vec_ct[1] = ZERO_CT;
        vec_pt[2] = C3_PT;  vec_key[2] = C3_KEY; vec_ct[2] = C3_CT;
        run_stream("post_reset", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
